// File: rtl/uart_rx_cmd_ctrl.sv
// Command-frame controller: turns uart_rx bytes SYNC,ADDR,DATA[,CHK] into one register write.
// Define UART_CMD_CHKSUM_EN to require a trailing CHK byte equal to (ADDR+DATA) mod 256.
module uart_rx_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 8680
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_Valid,
  input  logic       i_Wr_Ready,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Frame_Err,
  output logic       o_Overrun,
  output logic [7:0] o_Err_Count,
  output logic       o_Busy
);

  localparam int               CNT_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {S_HUNT, S_ADDR, S_DATA, S_CHK, S_WRITE} state_t;

  state_t           state;
  logic [CNT_W-1:0] idle_cnt;
  logic             in_frame;
  logic             timeout_hit;
  logic             chk_bad;
  logic             overrun_hit;
  logic             err_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef UART_CMD_CHKSUM_EN
  function automatic logic [7:0] chk_sum(input logic [7:0] a, input logic [7:0] d);
    return a + d;
  endfunction
`endif

  // A byte arriving on the timeout cycle takes priority over the timeout.
  always_comb begin
    in_frame    = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
    timeout_hit = in_frame && !i_Rx_DV && (idle_cnt == CNT_LAST);
    overrun_hit = (state == S_WRITE) && i_Rx_DV;
`ifdef UART_CMD_CHKSUM_EN
    chk_bad     = (state == S_CHK) && i_Rx_DV &&
                  (i_Rx_Byte != chk_sum(o_Wr_Addr, o_Wr_Data));
`else
    chk_bad     = 1'b0;
`endif
    err_hit     = timeout_hit || chk_bad || overrun_hit;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= S_HUNT;
      idle_cnt    <= '0;
      o_Wr_Valid  <= 1'b0;
      o_Wr_Addr   <= 8'h00;
      o_Wr_Data   <= 8'h00;
      o_Frame_Err <= 1'b0;
      o_Overrun   <= 1'b0;
      o_Err_Count <= 8'h00;
      o_Busy      <= 1'b0;
    end else begin
      o_Frame_Err <= timeout_hit || chk_bad;
      o_Overrun   <= overrun_hit;
      if (err_hit) begin
        o_Err_Count <= sat_inc(o_Err_Count);
      end

      if (!in_frame || i_Rx_DV || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      case (state)
        S_HUNT: begin
          if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
            state  <= S_ADDR;
            o_Busy <= 1'b1;
          end
        end
        S_ADDR: begin
          if (i_Rx_DV) begin
            o_Wr_Addr <= i_Rx_Byte;
            state     <= S_DATA;
          end else if (timeout_hit) begin
            state  <= S_HUNT;
            o_Busy <= 1'b0;
          end
        end
        S_DATA: begin
          if (i_Rx_DV) begin
            o_Wr_Data <= i_Rx_Byte;
`ifdef UART_CMD_CHKSUM_EN
            state     <= S_CHK;
`else
            state      <= S_WRITE;
            o_Wr_Valid <= 1'b1;
`endif
          end else if (timeout_hit) begin
            state  <= S_HUNT;
            o_Busy <= 1'b0;
          end
        end
`ifdef UART_CMD_CHKSUM_EN
        S_CHK: begin
          if (i_Rx_DV) begin
            if (chk_bad) begin
              state  <= S_HUNT;
              o_Busy <= 1'b0;
            end else begin
              state      <= S_WRITE;
              o_Wr_Valid <= 1'b1;
            end
          end else if (timeout_hit) begin
            state  <= S_HUNT;
            o_Busy <= 1'b0;
          end
        end
`endif
        // Address and data registers are frozen here until the handshake completes.
        S_WRITE: begin
          if (o_Wr_Valid && i_Wr_Ready) begin
            o_Wr_Valid <= 1'b0;
            state      <= S_HUNT;
            o_Busy     <= 1'b0;
          end
        end
        default: begin
          state      <= S_HUNT;
          o_Wr_Valid <= 1'b0;
          o_Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed frames plus random traffic against a frame-level model.
// Adapts to UART_CMD_CHKSUM_EN (4-byte frames) or its absence (3-byte frames).
module tb_uart_rx_cmd_ctrl;

  localparam int         TO   = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       overrun;
  logic [7:0] err_count;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int n_ferr = 0, n_ovr = 0, n_unstable = 0, n_wide = 0;
  int exp_ferr = 0, exp_ovr = 0, errs = 0;

  always #5 clk = ~clk;

  uart_rx_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_DV    (rx_dv),
    .i_Rx_Byte  (rx_byte),
    .o_Wr_Valid (wr_valid),
    .i_Wr_Ready (wr_ready),
    .o_Wr_Addr  (wr_addr),
    .o_Wr_Data  (wr_data),
    .o_Frame_Err(frame_err),
    .o_Overrun  (overrun),
    .o_Err_Count(err_count),
    .o_Busy     (busy)
  );

  // Monitor: accepted writes, error pulses, pulse width and held-request stability.
  logic        hold_prev = 1'b0, ferr_prev = 1'b0, ovr_prev = 1'b0;
  logic [15:0] held = 16'h0;
  always @(negedge clk) begin
    if (wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if ((frame_err && ferr_prev) || (overrun && ovr_prev)) n_wide++;
    if (hold_prev && wr_valid && ({wr_addr, wr_data} != held)) n_unstable++;
    hold_prev = wr_valid && !wr_ready;
    held      = {wr_addr, wr_data};
    ferr_prev = frame_err;
    ovr_prev  = overrun;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
  endtask

  function automatic logic [7:0] cksum(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] s;
    s = a + d;
    return s;
  endfunction

  // Sends one complete frame back to back; bad corrupts the checksum byte.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input bit bad);
    send_byte(SYNC);
    send_byte(a);
    send_byte(d);
`ifdef UART_CMD_CHKSUM_EN
    send_byte(bad ? cksum(a, d) + 8'd1 : cksum(a, d));
`else
    if (bad) rx_byte = 8'h00;
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(wr_valid), 0);
    check({tag, "_addr"},  32'(wr_addr), 0);
    check({tag, "_data"},  32'(wr_data), 0);
    check({tag, "_ferr"},  32'(frame_err), 0);
    check({tag, "_ovr"},   32'(overrun), 0);
    check({tag, "_cnt"},   32'(err_count), 0);
    check({tag, "_busy"},  32'(busy), 0);
  endtask

  // Good frame with ready held high: request visible next cycle, accepted on the following edge.
  task automatic frame_ok(input string tag, input logic [7:0] a, input logic [7:0] d);
    wr_ready = 1'b1;
    send_frame(a, d, 1'b0);
    check({tag, "_valid"}, 32'(wr_valid), 1);
    check({tag, "_addr"},  32'(wr_addr), 32'(a));
    check({tag, "_data"},  32'(wr_data), 32'(d));
    exp_q.push_back({a, d});
    tick(1);
    check({tag, "_done"},  32'(wr_valid), 0);
    check({tag, "_idle"},  32'(busy), 0);
  endtask

  task automatic send_late(input logic [7:0] b);
    tick(TO - 1);
    send_byte(b);
    check("late_ferr", 32'(frame_err), 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (busy && k < 400) begin
      wr_ready = 1'($urandom_range(0, 1));
      tick(1);
      k++;
    end
    check("wait_done_busy", 32'(busy), 0);
  endtask

  task automatic send_gapped(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] b[4];
    int nb, g;
    b[0] = SYNC; b[1] = a; b[2] = d; b[3] = cksum(a, d);
`ifdef UART_CMD_CHKSUM_EN
    nb = 4;
`else
    nb = 3;
`endif
    for (int j = 0; j < nb; j++) begin
      wr_ready = 1'($urandom_range(0, 1));
      send_byte(b[j]);
      if (j < nb - 1) begin
        g = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3));
        if (g > 0) tick(g);
      end
    end
  endtask

  initial begin
    logic [7:0] a, d, g;
    int kind, n;
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; wr_ready = 1'b0;
    tick(3);
    check_reset_state("reset");
    rst = 1'b0;
    tick(1);

    // Basic frame, ready high.
    frame_ok("t1", 8'h10, 8'h3C);

`ifdef UART_CMD_CHKSUM_EN
    // Checksum mismatch.
    send_frame(8'h10, 8'h3C, 1'b1);
    check("t2_ferr", 32'(frame_err), 1);
    check("t2_valid", 32'(wr_valid), 0);
    check("t2_busy", 32'(busy), 0);
    exp_ferr++; errs++;
    tick(1);
    check("t2_ferr_end", 32'(frame_err), 0);
    check("t2_cnt", 32'(err_count), 32'(sat(errs)));
`endif

    // Inter-byte timeout.
    send_byte(SYNC);
    send_byte(8'h10);
    tick(TO - 1);
    check("t3_early_ferr", 32'(frame_err), 0);
    check("t3_early_busy", 32'(busy), 1);
    tick(1);
    check("t3_ferr", 32'(frame_err), 1);
    check("t3_busy", 32'(busy), 0);
    exp_ferr++; errs++;
    tick(1);
    check("t3_ferr_end", 32'(frame_err), 0);
    check("t3_cnt", 32'(err_count), 32'(sat(errs)));

    // Every byte arriving on the last allowed cycle.
    wr_ready = 1'b1;
    send_byte(SYNC);
    send_late(8'h21);
    send_late(8'h43);
`ifdef UART_CMD_CHKSUM_EN
    send_late(8'h64);
`endif
    check("t3_late_valid", 32'(wr_valid), 1);
    check("t3_late_word", 32'({wr_addr, wr_data}), 'h2143);
    exp_q.push_back(16'h2143);
    tick(1);
    check("t3_late_done", 32'(busy), 0);

    // Backpressure with an overrun byte.
    wr_ready = 1'b0;
    a = 8'($urandom); d = 8'($urandom);
    send_frame(a, d, 1'b0);
    check("t4_valid", 32'(wr_valid), 1);
    tick(5);
    send_byte(8'h55);
    check("t4_ovr", 32'(overrun), 1);
    exp_ovr++; errs++;
    tick(1);
    check("t4_ovr_end", 32'(overrun), 0);
    check("t4_cnt", 32'(err_count), 32'(sat(errs)));
    tick(12);
    check("t4_hold_valid", 32'(wr_valid), 1);
    check("t4_hold_word", 32'({wr_addr, wr_data}), 32'({a, d}));
    check("t4_hold_busy", 32'(busy), 1);
    wr_ready = 1'b1;
    tick(1);
    check("t4_done", 32'(wr_valid), 0);
    exp_q.push_back({a, d});

    // Overrun on the handshake cycle; the dropped sync byte must not open a frame.
    wr_ready = 1'b0;
    a = 8'($urandom); d = 8'($urandom);
    send_frame(a, d, 1'b0);
    tick(2);
    wr_ready = 1'b1;
    send_byte(SYNC);
    check("t4b_ovr", 32'(overrun), 1);
    check("t4b_valid", 32'(wr_valid), 0);
    exp_q.push_back({a, d});
    exp_ovr++; errs++;
    send_byte(8'h11);
    check("t4b_busy", 32'(busy), 0);

    // Garbage ignored, wrapping checksum, sync byte as payload.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    check("t5_garbage_busy", 32'(busy), 0);
    frame_ok("t5", 8'hFF, 8'h02);
    frame_ok("t5_sync", SYNC, SYNC);

    // Reset in the middle of a frame.
    send_byte(SYNC);
    send_byte(8'h31);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_state("t6_rst_data");
    errs = 0;
    send_byte(8'h32);
    send_byte(8'h63);
    tick(2);
    check("t6_data_valid", 32'(wr_valid), 0);
    check("t6_data_busy", 32'(busy), 0);

    // Reset while a write is pending.
    wr_ready = 1'b0;
    send_frame(8'h44, 8'h55, 1'b0);
    check("t6_wr_pending", 32'(wr_valid), 1);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_state("t6_rst_write");
    wr_ready = 1'b1;
    tick(3);
    check("t6_wr_nowrite", 32'(wr_valid), 0);

    // Random traffic against the frame-level model.
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        g = 8'($urandom);
        if (g == SYNC) g = 8'h00;
        send_byte(g);
      end
      kind = $urandom_range(0, 5);
      a = 8'($urandom); d = 8'($urandom);
      if (kind == 0) begin
        send_byte(SYNC);
        n = $urandom_range(0, 1);
        if (n > 0) send_byte(a);
        tick(TO + 1);
        exp_ferr++; errs++;
      end else if (kind == 1) begin
`ifdef UART_CMD_CHKSUM_EN
        send_frame(a, d, 1'b1);
        tick(1);
        exp_ferr++; errs++;
`else
        send_gapped(a, d);
        exp_q.push_back({a, d});
        wait_done();
`endif
      end else begin
        send_gapped(a, d);
        exp_q.push_back({a, d});
        wait_done();
      end
    end
    check("rand_cnt", 32'(err_count), 32'(sat(errs)));

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      send_byte(SYNC);
      tick(TO + 1);
      exp_ferr++; errs++;
    end
    check("sat_cnt", 32'(err_count), 32'(sat(errs)));
    check("sat_cnt_255", 32'(err_count), 255);

    // Totals against the model.
    tick(2);
    check("writes_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("write_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check("ferr_pulses", 32'(n_ferr), 32'(exp_ferr));
    check("ovr_pulses", 32'(n_ovr), 32'(exp_ovr));
    check("hold_stable", 32'(n_unstable), 0);
    check("pulse_width", 32'(n_wide), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
